// File: rtl/neighbor_accumulator.sv
// Scans boid state memory and accumulates position/velocity sums of boids inside a box around a target boid.
// Latency: start in cycle 0 -> done in cycle NUM_BOIDS+2; results hold until the next accepted scan completes.
// Backpressure: none; start is ignored while busy, memory is read one address per cycle with fixed 1-cycle latency.
module neighbor_accumulator #(
   parameter int NUM_BOIDS = 32,
   parameter int IDX_W     = $clog2(NUM_BOIDS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [IDX_W-1:0] self_idx,
   input  logic [26:0]      x,
   input  logic [26:0]      y,
   input  logic [26:0]      visual_range,
   output logic [IDX_W-1:0] rd_addr,
   input  logic [26:0]      rd_xpos,
   input  logic [26:0]      rd_ypos,
   input  logic [26:0]      rd_xvel,
   input  logic [26:0]      rd_yvel,
   output logic             busy,
   output logic             done,
   output logic [26:0]      xpos_sum,
   output logic [26:0]      ypos_sum,
   output logic [26:0]      xvel_sum,
   output logic [26:0]      yvel_sum,
   output logic [IDX_W:0]   neighbor_cnt,
   output logic [26:0]      neighboring_boids_val,
   output logic             has_neighbors
);

   // Accumulators are wide enough that NUM_BOIDS 27-bit terms can never wrap.
   localparam int ACC_W = 27 + IDX_W + 1;
   localparam int LUT_N = 2 ** (IDX_W + 1);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BOIDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

   state_t state, state_nxt;
   logic   accept;

   logic [26:0]      x_s, y_s, vr_s;
   logic [IDX_W-1:0] self_s;
   logic             pipe_vld;
   logic [IDX_W-1:0] pipe_idx;

   logic [ACC_W-1:0] xp_acc, yp_acc, xv_acc, yv_acc;
   logic [ACC_W-1:0] xp_nxt, yp_nxt, xv_nxt, yv_nxt;
   logic [IDX_W:0]   cnt_acc, cnt_nxt;
   logic [27:0]      dx, dy, adx, ady;
   logic             hit;

   logic [26:0] recip_lut [0:LUT_N-1];

   function automatic logic [26:0] sat27(input logic [ACC_W-1:0] v);
      if ((&v[ACC_W-1:26]) || !(|v[ACC_W-1:26])) return v[26:0];
      else if (v[ACC_W-1])                       return 27'h400_0000;
      else                                       return 27'h3FF_FFFF;
   endfunction

   function automatic logic [ACC_W-1:0] sext(input logic [26:0] v);
      return {{(ACC_W-27){v[26]}}, v};
   endfunction

   // Reciprocal table: round-half-up(2^20/N) as floor((2^21+N)/(2N)); unused entries are zero.
   for (genvar n = 0; n < LUT_N; n++) begin : g_lut
      if (n == 0 || n > NUM_BOIDS) begin : g_zero
         assign recip_lut[n] = '0;
      end else begin : g_val
         assign recip_lut[n] = 27'((2097152 + n) / (2 * n));
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state and status decode; a start coincident with done is accepted from S_DONE.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_SCAN;
            end
         end
         S_SCAN: begin
            busy = 1'b1;
            if (rd_addr == LAST) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            busy      = 1'b1;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_SCAN;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Capture the target description so input changes mid-scan are harmless.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_s    <= '0;
         y_s    <= '0;
         vr_s   <= '0;
         self_s <= '0;
      end else if (accept) begin
         x_s    <= x;
         y_s    <= y;
         vr_s   <= visual_range;
         self_s <= self_idx;
      end
   end

   // Address generator plus the one-cycle valid/index pipe that lines up with returned data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_addr  <= '0;
         pipe_vld <= 1'b0;
         pipe_idx <= '0;
      end else begin
         pipe_vld <= (state == S_SCAN);
         pipe_idx <= rd_addr;
         if (accept)                                   rd_addr <= '0;
         else if (state == S_SCAN && rd_addr != LAST)  rd_addr <= rd_addr + 1'b1;
      end
   end

   // Neighbour test on the returned word; differences kept at 28 bits so they never wrap.
   always_comb begin
      dx     = {rd_xpos[26], rd_xpos} - {x_s[26], x_s};
      dy     = {rd_ypos[26], rd_ypos} - {y_s[26], y_s};
      adx    = dx[27] ? (~dx + 28'd1) : dx;
      ady    = dy[27] ? (~dy + 28'd1) : dy;
      hit    = pipe_vld && (pipe_idx != self_s) &&
               (adx < {1'b0, vr_s}) && (ady < {1'b0, vr_s});
      xp_nxt = xp_acc + (hit ? sext(rd_xpos) : '0);
      yp_nxt = yp_acc + (hit ? sext(rd_ypos) : '0);
      xv_nxt = xv_acc + (hit ? sext(rd_xvel) : '0);
      yv_nxt = yv_acc + (hit ? sext(rd_yvel) : '0);
      cnt_nxt = cnt_acc + {{IDX_W{1'b0}}, hit};
   end

   // Running sums; cleared when a scan is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset || accept) begin
         if (reset) begin
            xp_acc  <= '0;
            yp_acc  <= '0;
            xv_acc  <= '0;
            yv_acc  <= '0;
            cnt_acc <= '0;
         end else begin
            xp_acc  <= '0;
            yp_acc  <= '0;
            xv_acc  <= '0;
            yv_acc  <= '0;
            cnt_acc <= '0;
         end
      end else begin
         xp_acc  <= xp_nxt;
         yp_acc  <= yp_nxt;
         xv_acc  <= xv_nxt;
         yv_acc  <= yv_nxt;
         cnt_acc <= cnt_nxt;
      end
   end

   // Result registers load on the DRAIN->DONE edge so they include the last word and are valid with done.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xpos_sum              <= '0;
         ypos_sum              <= '0;
         xvel_sum              <= '0;
         yvel_sum              <= '0;
         neighbor_cnt          <= '0;
         neighboring_boids_val <= '0;
         has_neighbors         <= 1'b0;
      end else if (state == S_DRAIN) begin
         xpos_sum              <= sat27(xp_nxt);
         ypos_sum              <= sat27(yp_nxt);
         xvel_sum              <= sat27(xv_nxt);
         yvel_sum              <= sat27(yv_nxt);
         neighbor_cnt          <= cnt_nxt;
         neighboring_boids_val <= recip_lut[cnt_nxt];
         has_neighbors         <= (cnt_nxt != '0);
      end
   end

endmodule
